// File: rtl/rca_profiler_pkg.sv
// Shared types for the SBB successor profile cache (rca_sbb_profiler).
// Entry fields are sized for the widest supported build: ADDR_W <= 32, COUNT_W <= 16, NUM_ENTRIES <= 32.
package rca_profiler_pkg;

    localparam int unsigned PROF_ADDR_MAX_W  = 32;
    localparam int unsigned PROF_COUNT_MAX_W = 16;
    localparam int unsigned PROF_IDX_PORT_W  = 8;
    localparam int unsigned PROF_RD_W        = 32;

    typedef struct packed {
        logic [PROF_ADDR_MAX_W-1:0]  addr;
        logic                        valid;
        logic [PROF_COUNT_MAX_W-1:0] count;
    } profiler_entry_t;

    typedef enum logic [1:0] {
        OP_READ          = 2'd0,
        OP_CLEAR_ENTRY   = 2'd1,
        OP_TOGGLE_LOCK   = 2'd2,
        OP_CLEAR_PENDING = 2'd3
    } cmd_op_e;

    typedef enum logic [1:0] {
        FLD_ADDR    = 2'd0,
        FLD_VALID   = 2'd1,
        FLD_COUNT   = 2'd2,
        FLD_PENDING = 2'd3
    } cmd_field_e;

    typedef enum logic {
        CMD_IDLE = 1'b0,
        CMD_DONE = 1'b1
    } cmd_state_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rca_profiler_victim_sel.sv
// Allocation index for the profile table: lowest-index invalid entry, otherwise
// the lowest count with ties going to the lowest index.
module rca_profiler_victim_sel
    import rca_profiler_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES = 8,
    parameter int unsigned COUNT_W     = 8,
    parameter int unsigned IDX_W       = idx_width(NUM_ENTRIES)
) (
    input  logic [NUM_ENTRIES-1:0]         valid,
    input  logic [NUM_ENTRIES*COUNT_W-1:0] counts,
    output logic [IDX_W-1:0]               victim_idx
);

    logic               found_inv;
    logic [COUNT_W-1:0] best_cnt;
    logic [COUNT_W-1:0] cur_cnt;

    always_comb begin
        found_inv  = 1'b0;
        victim_idx = '0;
        best_cnt   = counts[COUNT_W-1:0];
        cur_cnt    = '0;
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            if (!valid[i] && !found_inv) begin
                found_inv  = 1'b1;
                victim_idx = IDX_W'(i);
            end
        end
        if (!found_inv) begin
            // strict less-than keeps the lowest index on ties
            for (int unsigned i = 1; i < NUM_ENTRIES; i++) begin
                cur_cnt = counts[i*COUNT_W +: COUNT_W];
                if (cur_cnt < best_cnt) begin
                    best_cnt   = cur_cnt;
                    victim_idx = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/rca_sbb_profiler.sv
// Short-backward-branch profile cache: counts taken SBBs, ages on saturation, pulses on hot entries.
// Optional periodic decay is built when RCA_PROFILER_DECAY_EN is defined.
module rca_sbb_profiler
    import rca_profiler_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES     = 8,
    parameter int unsigned COUNT_W         = 8,
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned OFFSET_W        = 21,
    parameter int unsigned SBB_MAX_DIST    = 256,
    parameter int unsigned TAKEN_THRESHOLD = 128,
    parameter int unsigned ID_W            = 3,
    parameter int unsigned DECAY_PERIOD    = 4096
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       br_valid,
    input  logic [ADDR_W-1:0]          br_pc,
    input  logic [OFFSET_W-1:0]        br_offset,
    input  logic                       br_taken,
    input  logic                       issue_new_req,
    input  logic [1:0]                 issue_op,
    input  logic [1:0]                 issue_field,
    input  logic [PROF_IDX_PORT_W-1:0] issue_index,
    input  logic [ID_W-1:0]            issue_id,
    output logic                       issue_ready,
    output logic                       wb_done,
    input  logic                       wb_ack,
    output logic [PROF_RD_W-1:0]       wb_rd,
    output logic [ID_W-1:0]            wb_id,
    output logic                       prof_exception,
    output logic                       prof_locked
);

    localparam int unsigned        IDX_W       = idx_width(NUM_ENTRIES);
    localparam logic [COUNT_W-1:0] CNT_MAX     = '1;
    localparam logic [COUNT_W-1:0] CNT_SAT_HIT = (CNT_MAX >> 1) + COUNT_W'(1);
    localparam logic [COUNT_W-1:0] CNT_THRESH  = COUNT_W'(TAKEN_THRESHOLD);
    localparam int                 SBB_MIN_OFF = -int'(SBB_MAX_DIST);

    profiler_entry_t tbl_q   [NUM_ENTRIES];
    profiler_entry_t dec_tbl [NUM_ENTRIES];
    profiler_entry_t tbl_d   [NUM_ENTRIES];

    logic [NUM_ENTRIES-1:0]         pending_q, pending_d;
    logic [NUM_ENTRIES-1:0]         signalled_q, signalled_d;
    logic [NUM_ENTRIES-1:0]         cross_q, cross_d;
    logic [NUM_ENTRIES-1:0]         dec_valid;
    logic [NUM_ENTRIES*COUNT_W-1:0] dec_counts;
    logic [IDX_W-1:0]               hit_idx, victim_idx, cmd_idx;
    logic [COUNT_W-1:0]             hit_cnt;
    logic signed [31:0]             off_ext;
    logic                           hit_any, is_sbb, br_op, decay_tick;
    logic                           locked_q, exc_q;
    logic                           accept, idx_ok, clr_entry, clr_pending;
    cmd_state_e                     state_q, state_d;
    cmd_op_e                        cmd_op;
    cmd_field_e                     cmd_field;
    logic [PROF_RD_W-1:0]           rd_val, wb_rd_q;
    logic [ID_W-1:0]                wb_id_q;

    function automatic logic [COUNT_W-1:0] cnt_of(input profiler_entry_t e);
        return e.count[COUNT_W-1:0];
    endfunction

    function automatic logic [PROF_COUNT_MAX_W-1:0] ext_cnt(input logic [COUNT_W-1:0] c);
        return PROF_COUNT_MAX_W'(c);
    endfunction

    // Branch qualification and lookup
    always_comb begin
        off_ext = 32'($signed(br_offset));
        is_sbb  = (off_ext < 0) && (off_ext >= SBB_MIN_OFF);
        br_op   = br_valid && br_taken && !locked_q;
        hit_any = 1'b0;
        hit_idx = '0;
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            if (!hit_any && tbl_q[i].valid && tbl_q[i].addr == PROF_ADDR_MAX_W'(br_pc)) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    // Decay stage runs ahead of the hit/alloc update so a coincident hit halves first, then adds one
    always_comb begin
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            dec_tbl[i] = tbl_q[i];
            if (decay_tick && tbl_q[i].valid) begin
                dec_tbl[i].count = tbl_q[i].count >> 1;
                if (cnt_of(tbl_q[i]) <= COUNT_W'(1)) dec_tbl[i].valid = 1'b0;
            end
            dec_valid[i]                      = dec_tbl[i].valid;
            dec_counts[i*COUNT_W +: COUNT_W] = cnt_of(dec_tbl[i]);
        end
    end

    rca_profiler_victim_sel #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .COUNT_W     (COUNT_W),
        .IDX_W       (IDX_W)
    ) u_victim_sel (
        .valid      (dec_valid),
        .counts     (dec_counts),
        .victim_idx (victim_idx)
    );

    always_comb begin
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) tbl_d[i] = dec_tbl[i];
        hit_cnt = cnt_of(dec_tbl[hit_idx]);
        if (br_op && hit_any) begin
            if (hit_cnt == CNT_MAX) begin
                for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
                    if (dec_tbl[i].valid) tbl_d[i].count = dec_tbl[i].count >> 1;
                end
                tbl_d[hit_idx].count = ext_cnt(CNT_SAT_HIT);
            end else begin
                tbl_d[hit_idx].count = ext_cnt(hit_cnt + COUNT_W'(1));
            end
            tbl_d[hit_idx].valid = 1'b1;
        end else if (br_op && is_sbb) begin
            tbl_d[victim_idx].addr  = PROF_ADDR_MAX_W'(br_pc);
            tbl_d[victim_idx].count = ext_cnt(COUNT_W'(1));
            tbl_d[victim_idx].valid = 1'b1;
        end
        if (clr_entry) begin
            tbl_d[cmd_idx].valid = 1'b0;
            tbl_d[cmd_idx].count = '0;
        end
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            cross_d[i] = tbl_d[i].valid && (cnt_of(tbl_d[i]) >= CNT_THRESH)
                         && (cnt_of(tbl_q[i]) < CNT_THRESH);
        end
    end

    assign prof_exception = |(pending_q & ~signalled_q) & ~exc_q;

    // Crossings merge in last so a same-cycle CLEAR_PENDING cannot swallow them
    always_comb begin
        pending_d   = pending_q;
        signalled_d = signalled_q;
        if (prof_exception) signalled_d = signalled_q | pending_q;
        if (clr_pending) begin
            pending_d   = '0;
            signalled_d = '0;
        end
        if (clr_entry) begin
            pending_d[cmd_idx]   = 1'b0;
            signalled_d[cmd_idx] = 1'b0;
        end
        pending_d = pending_d | cross_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_ENTRIES; i++) tbl_q[i] <= '0;
            pending_q   <= '0;
            signalled_q <= '0;
            cross_q     <= '0;
            exc_q       <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_ENTRIES; i++) tbl_q[i] <= tbl_d[i];
            pending_q   <= pending_d;
            signalled_q <= signalled_d;
            cross_q     <= cross_d;
            exc_q       <= prof_exception;
            if (accept && cmd_op == OP_TOGGLE_LOCK) locked_q <= ~locked_q;
        end
    end

    assign prof_locked = locked_q;

`ifdef RCA_PROFILER_DECAY_EN
    localparam int unsigned DEC_W = (DECAY_PERIOD <= 2) ? 1 : $clog2(DECAY_PERIOD);
    logic [DEC_W-1:0] decay_cnt_q;

    assign decay_tick = !locked_q && (decay_cnt_q == DEC_W'(DECAY_PERIOD - 1));

    always_ff @(posedge clk) begin
        if (!rst) decay_cnt_q <= '0;
        else if (!locked_q) decay_cnt_q <= decay_tick ? '0 : decay_cnt_q + DEC_W'(1);
    end
`else
    logic unused_decay_cfg;
    assign decay_tick       = 1'b0;
    assign unused_decay_cfg = (DECAY_PERIOD != 0);
`endif

    // Command decode and readout
    assign cmd_op      = cmd_op_e'(issue_op);
    assign cmd_field   = cmd_field_e'(issue_field);
    assign cmd_idx     = issue_index[IDX_W-1:0];
    assign idx_ok      = 32'(issue_index) < NUM_ENTRIES;
    assign accept      = issue_new_req && (state_q == CMD_IDLE);
    assign clr_entry   = accept && (cmd_op == OP_CLEAR_ENTRY) && idx_ok;
    assign clr_pending = accept && (cmd_op == OP_CLEAR_PENDING);

    always_comb begin
        rd_val = '0;
        case (cmd_op)
            OP_READ: begin
                case (cmd_field)
                    FLD_ADDR:    if (idx_ok) rd_val = PROF_RD_W'(tbl_q[cmd_idx].addr);
                    FLD_VALID:   if (idx_ok) rd_val[0] = tbl_q[cmd_idx].valid;
                    FLD_COUNT:   if (idx_ok) rd_val = PROF_RD_W'(tbl_q[cmd_idx].count);
                    FLD_PENDING: rd_val = PROF_RD_W'(pending_q);
                    default:     rd_val = '0;
                endcase
            end
            OP_TOGGLE_LOCK: rd_val[0] = ~locked_q;
            default:        rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state_q <= CMD_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            CMD_IDLE: if (accept) state_d = CMD_DONE;
            CMD_DONE: if (wb_ack) state_d = CMD_IDLE;
            default:  state_d = CMD_IDLE;
        endcase
    end

    always_comb begin
        wb_done     = (state_q == CMD_DONE);
        issue_ready = (state_q == CMD_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_rd_q <= '0;
            wb_id_q <= '0;
        end else if (accept) begin
            wb_rd_q <= rd_val;
            wb_id_q <= issue_id;
        end
    end

    assign wb_rd = wb_rd_q;
    assign wb_id = wb_id_q;

endmodule

// File: tb/tb_rca_sbb_profiler.sv
// Self-checking bench for rca_sbb_profiler; command results go through an expected-value queue.
// The decay scenario is exercised when RCA_PROFILER_DECAY_EN is defined.
module tb_rca_sbb_profiler;
    import rca_profiler_pkg::*;

    localparam int unsigned ID_W = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        br_valid = 1'b0;
    logic [31:0] br_pc = '0;
    logic [20:0] br_offset = '0;
    logic        br_taken = 1'b0;
    logic        issue_new_req = 1'b0;
    logic [1:0]  issue_op = '0;
    logic [1:0]  issue_field = '0;
    logic [7:0]  issue_index = '0;
    logic [ID_W-1:0] issue_id = '0;
    logic        issue_ready;
    logic        wb_done;
    logic        wb_ack = 1'b0;
    logic [31:0] wb_rd;
    logic [ID_W-1:0] wb_id;
    logic        prof_exception;
    logic        prof_locked;

    int total = 0;
    int bad   = 0;
    int exc_cnt  = 0;
    int exc_wide = 0;
    logic exc_prev = 1'b0;

    logic [31:0]     exp_rd_q [$];
    logic [ID_W-1:0] exp_id_q [$];
    logic [ID_W-1:0] id_ctr = '0;

    rca_sbb_profiler #(
        .NUM_ENTRIES     (8),
        .COUNT_W         (8),
        .ADDR_W          (32),
        .OFFSET_W        (21),
        .SBB_MAX_DIST    (256),
        .TAKEN_THRESHOLD (128),
        .ID_W            (ID_W),
        .DECAY_PERIOD    (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .br_valid       (br_valid),
        .br_pc          (br_pc),
        .br_offset      (br_offset),
        .br_taken       (br_taken),
        .issue_new_req  (issue_new_req),
        .issue_op       (issue_op),
        .issue_field    (issue_field),
        .issue_index    (issue_index),
        .issue_id       (issue_id),
        .issue_ready    (issue_ready),
        .wb_done        (wb_done),
        .wb_ack         (wb_ack),
        .wb_rd          (wb_rd),
        .wb_id          (wb_id),
        .prof_exception (prof_exception),
        .prof_locked    (prof_locked)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (prof_exception) begin
            exc_cnt++;
            if (exc_prev) exc_wide++;
        end
        exc_prev = prof_exception;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic br(input logic [31:0] pc, input int off, input logic taken);
        br_valid  = 1'b1;
        br_pc     = pc;
        br_offset = off[20:0];
        br_taken  = taken;
        tick();
        br_valid  = 1'b0;
    endtask

    task automatic br_n(input logic [31:0] pc, input int off, input int n);
        for (int k = 0; k < n; k++) br(pc, off, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        br_valid = 1'b0;
        issue_new_req = 1'b0;
        wb_ack = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic issue_send(input cmd_op_e op, input cmd_field_e fld, input logic [7:0] idx,
                              input logic [31:0] exp);
        issue_new_req = 1'b1;
        issue_op      = op;
        issue_field   = fld;
        issue_index   = idx;
        issue_id      = id_ctr;
        exp_rd_q.push_back(exp);
        exp_id_q.push_back(id_ctr);
        id_ctr++;
        tick();
        issue_new_req = 1'b0;
        br_valid      = 1'b0;
    endtask

    task automatic collect(input string tag);
        int unsigned waited = 0;
        logic [31:0]     e_rd;
        logic [ID_W-1:0] e_id;
        while (!wb_done && waited < 20) begin
            tick();
            waited++;
        end
        check({tag, "/latency"}, waited, 0);
        e_rd = exp_rd_q.pop_front();
        e_id = exp_id_q.pop_front();
        if (wb_done) begin
            check(tag, wb_rd, e_rd);
            check({tag, "/id"}, 32'(wb_id), 32'(e_id));
        end
        wb_ack = 1'b1;
        tick();
        wb_ack = 1'b0;
        check({tag, "/ack"}, 32'(wb_done), 0);
    endtask

    task automatic cmd(input string tag, input cmd_op_e op, input cmd_field_e fld,
                       input logic [7:0] idx, input logic [31:0] exp);
        issue_send(op, fld, idx, exp);
        collect(tag);
    endtask

    initial begin
        tick();
        tick();
        check("rst_ready",  32'(issue_ready),    1);
        check("rst_done",   32'(wb_done),        0);
        check("rst_exc",    32'(prof_exception), 0);
        check("rst_locked", 32'(prof_locked),    0);
        check("rst_rd",     wb_rd,               0);
        check("rst_id",     32'(wb_id),          0);
        rst = 1'b1;

`ifdef RCA_PROFILER_DECAY_EN
        // decay fires on the 16th edge after reset release: 8 -> 4, 1 -> invalid
        br_n(32'h500, -16, 8);
        br(32'h600, -16, 1'b1);
        repeat (8) tick();
        cmd("dec_cnt0", OP_READ, FLD_COUNT, 8'd0, 32'd4);
        cmd("dec_val1", OP_READ, FLD_VALID, 8'd1, 32'd0);
        cmd("dec_val0", OP_READ, FLD_VALID, 8'd0, 32'd1);
`else
        br(32'h100, -16, 1'b1);
        cmd("t1_cnt0",  OP_READ, FLD_COUNT, 8'd0, 32'd1);
        cmd("t1_addr0", OP_READ, FLD_ADDR,  8'd0, 32'h100);
        cmd("t1_val1",  OP_READ, FLD_VALID, 8'd1, 32'd0);

        // 128th hit crosses threshold; pulse appears two edges later for one cycle
        br_n(32'h100, -16, 127);
        check("t2_exc_early", 32'(prof_exception), 0);
        tick();
        check("t2_exc_pulse", 32'(prof_exception), 1);
        tick();
        check("t2_exc_end", 32'(prof_exception), 0);
        repeat (3) tick();
        check("t2_exc_count", exc_cnt, 1);
        cmd("t2_pend",    OP_READ,          FLD_PENDING, 8'd5, 32'h1);
        cmd("t2_cnt0",    OP_READ,          FLD_COUNT,   8'd0, 32'd128);
        cmd("t2_clrpend", OP_CLEAR_PENDING, FLD_ADDR,    8'd0, 32'd0);
        cmd("t2_pend0",   OP_READ,          FLD_PENDING, 8'd0, 32'd0);
        check("t2_exc_after_clr", exc_cnt, 1);

        br_n(32'h100, -16, 127);
        br_n(32'h200, -16, 40);
        cmd("t3_cnt0_sat", OP_READ, FLD_COUNT, 8'd0, 32'd255);
        cmd("t3_cnt1_pre", OP_READ, FLD_COUNT, 8'd1, 32'd40);
        br(32'h100, -16, 1'b1);
        cmd("t3_cnt0_age", OP_READ, FLD_COUNT, 8'd0, 32'd128);
        cmd("t3_cnt1_age", OP_READ, FLD_COUNT, 8'd1, 32'd20);
        check("t3_exc_count", exc_cnt, 1);

        do_reset();
        for (int i = 0; i < 8; i++) br(32'h1000 + 32'(i * 4), -8, 1'b1);
        br_n(32'h1000, -8, 4);
        for (int i = 1; i < 8; i++) br_n(32'h1000 + 32'(i * 4), -8, 2);
        cmd("t4_cnt0", OP_READ, FLD_COUNT, 8'd0, 32'd5);
        cmd("t4_cnt7", OP_READ, FLD_COUNT, 8'd7, 32'd3);
        br(32'h2000, -8, 1'b1);
        cmd("t4_victim_addr", OP_READ, FLD_ADDR,  8'd1, 32'h2000);
        cmd("t4_victim_cnt",  OP_READ, FLD_COUNT, 8'd1, 32'd1);
        br(32'h3000, -512, 1'b1);
        br(32'h3004, -257, 1'b1);
        br(32'h3008, 0, 1'b1);
        br(32'h300C, 4, 1'b1);
        br(32'h3010, -16, 1'b0);
        cmd("t4_nonsbb_addr", OP_READ, FLD_ADDR, 8'd1, 32'h2000);
        br(32'h4000, -256, 1'b1);
        cmd("t4_edge_sbb", OP_READ, FLD_ADDR,  8'd1, 32'h4000);
        cmd("t4_oor_read", OP_READ, FLD_ADDR,  8'd8, 32'd0);
        cmd("t4_val7",     OP_READ, FLD_VALID, 8'd7, 32'd1);
        br(32'h1000, 64, 1'b1);
        cmd("t4_fwd_hit",  OP_READ, FLD_COUNT, 8'd0, 32'd6);

        cmd("t5_lock", OP_TOGGLE_LOCK, FLD_ADDR, 8'd0, 32'd1);
        check("t5_locked", 32'(prof_locked), 1);
        br_n(32'h1008, -8, 10);
        br(32'h5000, -8, 1'b1);
        cmd("t5_lock_cnt2",  OP_READ, FLD_COUNT, 8'd2, 32'd3);
        cmd("t5_lock_alloc", OP_READ, FLD_ADDR,  8'd1, 32'h4000);
        cmd("t5_unlock", OP_TOGGLE_LOCK, FLD_ADDR, 8'd0, 32'd0);
        check("t5_unlocked", 32'(prof_locked), 0);
        br_valid = 1'b1; br_pc = 32'h1008; br_offset = 21'h1FFFF8; br_taken = 1'b1;
        cmd("t5_clr2",     OP_CLEAR_ENTRY, FLD_ADDR,  8'd2, 32'd0);
        cmd("t5_clr2_val", OP_READ,        FLD_VALID, 8'd2, 32'd0);
        cmd("t5_clr2_cnt", OP_READ,        FLD_COUNT, 8'd2, 32'd0);
        br_valid = 1'b1; br_pc = 32'h100C; br_offset = 21'h1FFFF8; br_taken = 1'b1;
        cmd("t5_read_pre",  OP_READ, FLD_COUNT, 8'd3, 32'd3);
        cmd("t5_read_post", OP_READ, FLD_COUNT, 8'd3, 32'd4);
        cmd("t5_clr_oor",   OP_CLEAR_ENTRY, FLD_ADDR, 8'd9, 32'd0);
        cmd("t5_val3",      OP_READ, FLD_VALID, 8'd3, 32'd1);
`endif

        issue_send(OP_READ, FLD_VALID, 8'd0, 32'd1);
        for (int k = 0; k < 5; k++) begin
            check("hold_done",  32'(wb_done),     1);
            check("hold_ready", 32'(issue_ready), 0);
            check("hold_rd",    wb_rd,            32'd1);
            tick();
        end
        collect("hold_result");

        issue_send(OP_READ, FLD_COUNT, 8'd0, 32'd0);
        rst = 1'b0;
        tick();
        check("rstmid_done",  32'(wb_done),     0);
        check("rstmid_ready", 32'(issue_ready), 1);
        rst = 1'b1;
        void'(exp_rd_q.pop_front());
        void'(exp_id_q.pop_front());
        cmd("rstmid_val0", OP_READ, FLD_VALID, 8'd0, 32'd0);

        check("exc_width", exc_wide, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
